// File: rtl/mem_port_ctrl_if.sv
// mem_port_ctrl_if: requester- and memory-side signal bundle for mem_port_ctrl.
// Optional signal rsp_err is present only when MEM_PORT_RANGE_CHECK_EN is defined.
//
// Handshake: a request transfers on the posedge where req_valid && req_ready are
// both high. req_ready is high only while the controller is idle, and the request
// fields are copied at that edge, so they may change freely afterwards.
// rsp_valid is a single-cycle pulse with no ready: the consumer takes it in that cycle.
interface mem_port_ctrl_if;
    logic        req_valid;
    logic        req_write;
    logic [11:0] req_adr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_write;
    logic [15:0] rsp_rdata;
`ifdef MEM_PORT_RANGE_CHECK_EN
    logic        rsp_err;
`endif
    logic        MemRead;
    logic        MemWrite;
    logic [11:0] adr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    // Requester plus memory: drives requests and memory read data.
    modport master (
        output req_valid, req_write, req_adr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata,
               MemRead, MemWrite, adr, mem_wdata
`ifdef MEM_PORT_RANGE_CHECK_EN
             , rsp_err
`endif
    );

    // Controller: accepts requests, drives the memory port and the response.
    modport slave (
        input  req_valid, req_write, req_adr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_write, rsp_rdata,
               MemRead, MemWrite, adr, mem_wdata
`ifdef MEM_PORT_RANGE_CHECK_EN
             , rsp_err
`endif
    );
endinterface

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: single-outstanding memory port controller.
// A request is latched in IDLE, performed in ACCESS (one write cycle, or
// WAIT_CYCLES read cycles ending in a data capture), and reported in RESP.
// Optional feature macro: MEM_PORT_RANGE_CHECK_EN adds rsp_err and rejects
// addresses above ADR_LIMIT without touching memory.
// dbg_state exposes the FSM state (0 IDLE, 1 ACCESS, 2 RESP).
module mem_port_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [11:0] ADR_LIMIT   = 12'hFFF
) (
    input  logic           clk,
    input  logic           rst,
    mem_port_ctrl_if.slave bus,
    output logic [1:0]     dbg_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [11:0] adr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        write_q;
    logic        accept;
    logic        last_read;
    logic        capture;
    logic        adr_bad;

`ifdef MEM_PORT_RANGE_CHECK_EN
    logic        err_q;
    assign adr_bad = (bus.req_adr > ADR_LIMIT);
`else
    logic        unused_adr_limit;
    assign unused_adr_limit = ^ADR_LIMIT;
    assign adr_bad          = 1'b0;
`endif

    assign accept    = bus.req_valid && (state == IDLE);
    assign last_read = (cnt <= 4'd1);
    assign capture   = (state == ACCESS) && !write_q && last_read;

    assign bus.adr       = adr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rsp_rdata = rdata_q;
    assign dbg_state     = state;

    // State register; reset returns to IDLE at once so MemWrite drops without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request copy, read wait counter and read data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            adr_q   <= 12'd0;
            wdata_q <= 16'd0;
            write_q <= 1'b0;
            rdata_q <= 16'd0;
`ifdef MEM_PORT_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                adr_q   <= bus.req_adr;
                wdata_q <= bus.req_wdata;
                write_q <= bus.req_write;
                cnt     <= WAIT_LOAD;
`ifdef MEM_PORT_RANGE_CHECK_EN
                err_q   <= adr_bad;
`endif
            end else if ((state == ACCESS) && !write_q && !last_read) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Next-state: out-of-range requests skip ACCESS; reads leave on the last wait cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = adr_bad ? RESP : ACCESS;
            ACCESS:  if (write_q || last_read) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state only, so strobes are exclusive and zero outside ACCESS.
    always_comb begin
        bus.req_ready = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_write = 1'b0;
`ifdef MEM_PORT_RANGE_CHECK_EN
        bus.rsp_err   = 1'b0;
`endif
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
            end
            ACCESS: begin
                bus.MemWrite = write_q;
                bus.MemRead  = !write_q;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_write = write_q;
`ifdef MEM_PORT_RANGE_CHECK_EN
                bus.rsp_err   = err_q;
`endif
            end
            default: begin
                bus.req_ready = 1'b0;
            end
        endcase
    end
endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: read cycles with MemRead held before mem_rdata is captured; legal range 1..15.
REQ-002 Parameter ADR_LIMIT, default 12'hFFF: highest legal word address; used only under MEM_PORT_RANGE_CHECK_EN.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  requester presents an access.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_adr  input  12  word address.
REQ-008 req_wdata  input  16  write data.
REQ-009 req_ready  output  1  controller can accept a request this cycle.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_write  output  1  completed access was a write.
REQ-012 rsp_rdata  output  16  registered read data.
REQ-013 MemRead  output  1  memory read enable.
REQ-014 MemWrite  output  1  memory write enable; memory commits on the posedge where it is high.
REQ-015 adr  output  12  memory address.
REQ-016 mem_wdata  output  16  drives the memory data_in.
REQ-017 mem_rdata  input  16  memory data_out (combinational, 0 when MemRead low).

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-019 Acceptance SHALL occur on a posedge with req_valid && req_ready: latch req_adr, req_wdata, req_write; go to ACCESS.
REQ-020 adr and mem_wdata SHALL be driven from the latched registers; they hold the last accepted values in all states.
REQ-021 Write in ACCESS: MemWrite = 1 for exactly one cycle; next state RESP.
REQ-022 Read in ACCESS: MemRead = 1 for exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded at acceptance.
REQ-023 Read capture: on the posedge ending the last ACCESS cycle, mem_rdata is registered into rsp_rdata; next state RESP.
REQ-024 In RESP: rsp_valid = 1 for one cycle and rsp_write = the latched req_write; next state IDLE.
REQ-025 rsp_valid SHALL NOT have back-pressure; the consumer takes the response in the RESP cycle.
REQ-026 Latency from the accept edge to rsp_valid high SHALL be WAIT_CYCLES+1 cycles for a read and 2 cycles for a write.
REQ-027 MemRead and MemWrite SHALL never be high together, and both SHALL be 0 outside ACCESS.
REQ-028 rsp_rdata SHALL change only at a read capture; writes leave it unchanged.
REQ-029 req_valid outside IDLE SHALL be ignored, with no queueing; back-to-back requests are accepted no sooner than the cycle after RESP.
REQ-030 Requester inputs SHALL be don't-care after acceptance, because the latched copies are used.

Reset
REQ-031 When rst is asserted, all state SHALL clear asynchronously: state = IDLE, counter = 0, adr = 0, mem_wdata = 0, rsp_rdata = 0, rsp_valid = 0, rsp_write = 0, MemRead = 0, MemWrite = 0.
REQ-032 If rst is asserted during a write ACCESS before the commit edge, MemWrite SHALL drop immediately, so no memory write occurs.
REQ-033 After rst is released, req_ready SHALL be 1 in the first cycle.

Configuration
REQ-034 Macro MEM_PORT_RANGE_CHECK_EN, when defined, SHALL add output rsp_err (1 bit, reset 0).
REQ-035 With the macro, an accepted request with latched adr > ADR_LIMIT SHALL go IDLE -> RESP directly, with no MemRead/MemWrite, rsp_err = 1 during RESP, and rsp_rdata unchanged.
REQ-036 With the macro, rsp_err SHALL be 0 in all other cycles.
REQ-037 Without the macro, the rsp_err port and the ADR_LIMIT comparison SHALL be absent, and every address is accessed.

Verification
REQ-038 WAIT_CYCLES=1: write adr 12'h010 data 16'hBEEF -> MemWrite high for one cycle, rsp_valid 2 cycles after acceptance with rsp_write=1; then read 12'h010 -> rsp_rdata=16'hBEEF, rsp_valid 2 cycles after acceptance.
REQ-039 WAIT_CYCLES=3: read 12'h020 holding 16'h1234 -> MemRead high for exactly 3 cycles, rsp_valid at accept+4, rsp_rdata=16'h1234.
REQ-040 Hold req_valid high continuously with alternating read/write -> one access per IDLE cycle; req_ready low in ACCESS/RESP; never MemRead&&MemWrite.
REQ-041 Assert rst mid-write (adr 12'h030, data 16'h5555, memory previously 16'h0000) -> MemWrite falls asynchronously, the memory word stays 16'h0000, all outputs are 0, req_ready=1 after release.
REQ-042 Macro on, ADR_LIMIT=12'h0FF: read 12'h100 -> no MemRead, rsp_valid at accept+1, rsp_err=1, rsp_rdata unchanged; read 12'h0FF -> rsp_err=0.
